// File: rtl/ppu_pkg.sv
// Shared PPU definitions: STAT mode encoding and default scanline geometry.
// Used by the mode sequencer and the mode 2/mode 3 engines.
package ppu_pkg;

   typedef enum logic [1:0] {
      MODE_HBLANK = 2'd0,
      MODE_VBLANK = 2'd1,
      MODE_OAM    = 2'd2,
      MODE_XFER   = 2'd3
   } mode_t;

   localparam int DEF_LINE_CYCLES   = 456;
   localparam int DEF_VISIBLE_LINES = 144;
   localparam int DEF_VBLANK_LINES  = 10;
   localparam int DEF_OAM_CYCLES    = 80;
   localparam int DEF_DOT_W         = 9;

endpackage

// File: rtl/ppu_stat_irq.sv
// STAT interrupt source: combines the enabled STAT conditions into stat_line.
// PPU_STAT_BLOCKING_EN selects a rising-edge pulse instead of the registered level.
module ppu_stat_irq
   import ppu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_en,
   input  logic       lyc_eq,
   input  logic [1:0] mode,
   input  logic [3:0] stat_sel,
   output logic       stat_irq
);

   logic stat_line;

   always_comb begin
      stat_line = 1'b0;
      if (lcd_en)
         stat_line = (lyc_eq & stat_sel[3])
                   | ((mode == MODE_OAM)    & stat_sel[2])
                   | ((mode == MODE_VBLANK) & stat_sel[1])
                   | ((mode == MODE_HBLANK) & stat_sel[0]);
   end

`ifdef PPU_STAT_BLOCKING_EN
   // Sources that overlap with no low gap merge into one request.
   logic line_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q   <= 1'b0;
         stat_irq <= 1'b0;
      end else begin
         line_q   <= stat_line;
         stat_irq <= stat_line & ~line_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) stat_irq <= 1'b0;
      else     stat_irq <= stat_line;
   end
`endif

endmodule

// File: rtl/ppu_mode_sequencer.sv
// Scanline/mode timing controller: dot/LY counters, STAT mode 2->3->0 / 1 sequence,
// engine start pulses and interrupts. PPU_STAT_BLOCKING_EN selects pulsed STAT irq.
module ppu_mode_sequencer
   import ppu_pkg::*;
#(
   parameter int LINE_CYCLES   = DEF_LINE_CYCLES,
   parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
   parameter int VBLANK_LINES  = DEF_VBLANK_LINES,
   parameter int OAM_CYCLES    = DEF_OAM_CYCLES,
   parameter int DOT_W         = DEF_DOT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lcd_en,
   input  logic [7:0]       lyc,
   input  logic [3:0]       stat_sel,
   input  logic             m3_done,
   output logic             m2_start,
   output logic             m3_start,
   output logic [1:0]       mode,
   output logic [7:0]       ly,
   output logic [DOT_W-1:0] dot,
   output logic             lyc_eq,
   output logic             stat_irq,
   output logic             vblank_irq,
   output logic             overrun
);

   localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(LINE_CYCLES - 1);
   localparam logic [DOT_W-1:0] OAM_LAST = DOT_W'(OAM_CYCLES - 1);
   localparam logic [7:0]       LY_LAST  = 8'(VISIBLE_LINES + VBLANK_LINES - 1);
   localparam logic [7:0]       LY_VIS   = 8'(VISIBLE_LINES);

   // active_q low means the next enabled cycle restarts the frame at line 0 mode 2.
   logic             active_q, active_n;
   mode_t            mode_q, mode_n;
   logic [7:0]       ly_q, ly_n;
   logic [DOT_W-1:0] dot_q, dot_n;
   logic             m2_q, m2_n, m3_q, m3_n, vbl_q, vbl_n, ovr_q, ovr_n, lyc_eq_q;

   always_comb begin
      active_n = active_q;
      mode_n   = mode_q;
      ly_n     = ly_q;
      dot_n    = dot_q;
      m2_n     = 1'b0;
      m3_n     = 1'b0;
      vbl_n    = 1'b0;
      ovr_n    = ovr_q;
      if (!lcd_en) begin
         active_n = 1'b0;
         mode_n   = MODE_HBLANK;
         ly_n     = '0;
         dot_n    = '0;
      end else if (!active_q) begin
         active_n = 1'b1;
         mode_n   = MODE_OAM;
         ly_n     = '0;
         dot_n    = '0;
         m2_n     = 1'b1;
      end else if (dot_q == DOT_LAST) begin
         dot_n = '0;
         ly_n  = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
         if (ly_n < LY_VIS) begin
            mode_n = MODE_OAM;
            m2_n   = 1'b1;
         end else begin
            mode_n = MODE_VBLANK;
            vbl_n  = (ly_n == LY_VIS);
         end
         // A done pulse on the last dot still counts as finishing in time.
         if (mode_q == MODE_XFER && !m3_done)
            ovr_n = 1'b1;
      end else begin
         dot_n = dot_q + 1'b1;
         case (mode_q)
            MODE_OAM: if (dot_q == OAM_LAST) begin
               mode_n = MODE_XFER;
               m3_n   = 1'b1;
            end
            MODE_XFER: if (m3_done) mode_n = MODE_HBLANK;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         mode_q   <= MODE_OAM;
         ly_q     <= '0;
         dot_q    <= '0;
         m2_q     <= 1'b0;
         m3_q     <= 1'b0;
         vbl_q    <= 1'b0;
         ovr_q    <= 1'b0;
         lyc_eq_q <= 1'b0;
      end else begin
         active_q <= active_n;
         mode_q   <= mode_n;
         ly_q     <= ly_n;
         dot_q    <= dot_n;
         m2_q     <= m2_n;
         m3_q     <= m3_n;
         vbl_q    <= vbl_n;
         ovr_q    <= ovr_n;
         lyc_eq_q <= (ly_n == lyc);
      end
   end

   ppu_stat_irq u_stat_irq (
      .clk      (clk),
      .rst      (rst),
      .lcd_en   (lcd_en),
      .lyc_eq   (lyc_eq_q),
      .mode     (mode_q),
      .stat_sel (stat_sel),
      .stat_irq (stat_irq)
   );

   assign mode       = mode_q;
   assign ly         = ly_q;
   assign dot        = dot_q;
   assign m2_start   = m2_q;
   assign m3_start   = m3_q;
   assign vblank_irq = vbl_q;
   assign overrun    = ovr_q;
   assign lyc_eq     = lyc_eq_q;

endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// Directed bench for ppu_mode_sequencer at default geometry; expected values hand-derived.
module tb_ppu_mode_sequencer;

   localparam int L = 456;
   localparam int F = 70224;

   logic       clk = 1'b0;
   logic       rst, lcd_en, m3_done;
   logic [7:0] lyc;
   logic [3:0] stat_sel;
   logic       m2_start, m3_start, lyc_eq, stat_irq, vblank_irq, overrun;
   logic [1:0] mode;
   logic [7:0] ly;
   logic [8:0] dot;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, done_dot = 251;
   int vbl_cnt = 0, lyc_cnt = 0, stat_cnt = 0, m2_cnt = 0, m3_cnt = 0;

   ppu_mode_sequencer dut (
      .clk(clk), .rst(rst), .lcd_en(lcd_en), .lyc(lyc), .stat_sel(stat_sel),
      .m3_done(m3_done), .m2_start(m2_start), .m3_start(m3_start), .mode(mode),
      .ly(ly), .dot(dot), .lyc_eq(lyc_eq), .stat_irq(stat_irq),
      .vblank_irq(vblank_irq), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Advance to absolute cycle target, pulsing m3_done at dot done_dot of every line.
   task automatic run_to(input int target);
      while (cyc < target) begin
         m3_done = (done_dot >= 0) && ((cyc % L) == done_dot);
         if (vblank_irq) vbl_cnt++;
         if (lyc_eq)     lyc_cnt++;
         if (stat_irq)   stat_cnt++;
         if (m2_start)   m2_cnt++;
         if (m3_start)   m3_cnt++;
         tick();
      end
      m3_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; lcd_en = 1'b1; m3_done = 1'b0; lyc = 8'd5; stat_sel = 4'b1000;
      tick(); tick(); tick();
      chk("rst_mode", mode, 2);
      chk("rst_ly", ly, 0);
      chk("rst_dot", dot, 0);
      chk("rst_m2", m2_start, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_vbl", vblank_irq, 0);

      rst = 1'b0;
      tick();
      cyc = 0;
      chk("rel_m2", m2_start, 1);
      chk("rel_dot", dot, 0);
      chk("rel_mode", mode, 2);

      // line 0: mode 2 dots 0-79, mode 3 dots 80-251, mode 0 from 252
      run_to(79);  chk("l0_d79_mode", mode, 2); chk("l0_d79_dot", dot, 79);
      run_to(80);  chk("l0_d80_mode", mode, 3); chk("l0_m3_start", m3_start, 1);
      run_to(81);  chk("l0_m3_pulse", m3_start, 0);
      run_to(251); chk("l0_d251_mode", mode, 3);
      run_to(252); chk("l0_d252_mode", mode, 0);
      run_to(455); chk("l0_d455_ly", ly, 0); chk("l0_d455_dot", dot, 455);
      run_to(456); chk("l1_ly", ly, 1); chk("l1_dot", dot, 0);
      chk("l1_mode", mode, 2); chk("l1_m2", m2_start, 1);

      // LYC match on line 5
      run_to(5*L-1); chk("lyc_before", lyc_eq, 0);
      run_to(5*L);   chk("lyc_first", lyc_eq, 1); chk("lyc_ly", ly, 5);
`ifdef PPU_STAT_BLOCKING_EN
      run_to(5*L+1); chk("lyc_pulse", stat_irq, 1);
      run_to(5*L+2); chk("lyc_pulse_end", stat_irq, 0);
`else
      chk("lyc_lvl_lag", stat_irq, 0);
      run_to(5*L+1); chk("lyc_lvl_on", stat_irq, 1);
`endif
      run_to(6*L-1); chk("lyc_last", lyc_eq, 1);
      run_to(6*L);   chk("lyc_after", lyc_eq, 0);
`ifndef PPU_STAT_BLOCKING_EN
      chk("lyc_lvl_tail", stat_irq, 1);
      run_to(6*L+1); chk("lyc_lvl_off", stat_irq, 0);
`endif

      // vertical blank
      run_to(144*L-1); chk("pre_vbl_ly", ly, 143); chk("pre_vbl_irq", vblank_irq, 0);
      run_to(144*L);   chk("vbl_mode", mode, 1); chk("vbl_ly", ly, 144);
      chk("vbl_irq", vblank_irq, 1); chk("vbl_no_m2", m2_start, 0);
      run_to(144*L+1); chk("vbl_irq_end", vblank_irq, 0);
      run_to(F-1);     chk("end_ly", ly, 153); chk("end_mode", mode, 1);
      run_to(F);
      chk("frame_ly", ly, 0); chk("frame_dot", dot, 0);
      chk("frame_mode", mode, 2); chk("frame_m2", m2_start, 1);
      chk("frame_vbl_cnt", vbl_cnt, 1);
      chk("frame_lyc_cnt", lyc_cnt, L);
      chk("frame_m2_cnt", m2_cnt, 144);
      chk("frame_m3_cnt", m3_cnt, 144);
      chk("frame_ovr", overrun, 0);
`ifdef PPU_STAT_BLOCKING_EN
      chk("frame_stat_cnt", stat_cnt, 1);
`else
      chk("frame_stat_cnt", stat_cnt, L);
`endif

      // mode 0 -> mode 2 keeps stat_line high across the line boundary
      stat_sel = 4'b0101;
      run_to(F+L);
      stat_cnt = 0;
      run_to(F+2*L);
`ifdef PPU_STAT_BLOCKING_EN
      chk("sel0101_pulses", stat_cnt, 1);
`else
      chk("sel0101_level", stat_cnt, 284);
`endif

      // line 2: done on the last dot is not an overrun
      done_dot = 455;
      run_to(F+3*L-1); chk("late_done_mode", mode, 3);
      run_to(F+3*L);
      chk("late_done_ovr", overrun, 0); chk("late_done_mode2", mode, 2);
      chk("late_done_ly", ly, 3);

      // line 3: done only during mode 2 (ignored), never in mode 3
      done_dot = 40;
      run_to(F+3*L+41); chk("m2_done_ignored", mode, 2);
      run_to(F+3*L+81); chk("m3_held", mode, 3);
      run_to(F+4*L);
      chk("ovr_set", overrun, 1); chk("ovr_mode", mode, 2);
      chk("ovr_ly", ly, 4); chk("ovr_dot", dot, 0); chk("ovr_m2", m2_start, 1);

      // lcd off in mid mode 3, then back on
      done_dot = -1;
      run_to(F+4*L+100); chk("pre_off_mode", mode, 3);
      lcd_en = 1'b0;
      tick();
      chk("off_mode", mode, 0); chk("off_ly", ly, 0); chk("off_dot", dot, 0);
      chk("off_ovr_held", overrun, 1); chk("off_m2", m2_start, 0);
      tick(); tick();
      chk("off_dot_hold", dot, 0); chk("off_stat", stat_irq, 0);
      lcd_en = 1'b1;
      tick();
      chk("on_mode", mode, 2); chk("on_m2", m2_start, 1);
      chk("on_dot", dot, 0); chk("on_ly", ly, 0);
      tick();
      chk("on_dot1", dot, 1); chk("on_m2_end", m2_start, 0);

      rst = 1'b1;
      tick();
      chk("rst_ovr_clear", overrun, 0);
      chk("rst_mode2", mode, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
